// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant bundle between the MERC-16 bus requesters and the arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int N = 2
) ();
    localparam int M = 2**N;

    logic [M-1:0] Req;       // bit i = requester i wants the bus
    logic         Done;      // current owner releases the bus this cycle
    logic [M-1:0] Grant;     // one-hot grant, zero when no owner
    logic [N-1:0] GrantIdx;  // index of current owner, zero when no owner
    logic         Valid;     // high while a grant is held
    logic         Timeout;   // one-cycle pulse on a forced release

    modport master (
        output Req,
        output Done,
        input  Grant,
        input  GrantIdx,
        input  Valid,
        input  Timeout
    );

    modport slave (
        input  Req,
        input  Done,
        output Grant,
        output GrantIdx,
        output Valid,
        output Timeout
    );
endinterface : bus_arbiter_if

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the MERC-16 memory/peripheral bus. A grant is held
// until the owner raises Done or drops its request; the search pointer then
// moves one past the old owner, so every requester gets a turn. One IDLE
// cycle always separates consecutive grants. All outputs are registered.
//
// Optional build macro ARB_TIMEOUT_EN: adds a hold counter that force-releases
// a grant after TIMEOUT cycles and pulses Timeout on that release. Without the
// macro there is no counter, Timeout is tied low and grants are unbounded.
//
// M must equal 2**N: the rotating search relies on the N-bit index wrapping.
// The interface instance must be built with the same N as this module.
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N       = 2,
    parameter int M       = 2**N,
    parameter int TIMEOUT = 16
) (
    input  logic         Clk,
    input  logic         Reset,   // synchronous, active low
    bus_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e       state_q,     state_d;
    logic [N-1:0] pointer_q,   pointer_d;
    logic [M-1:0] grant_q,     grant_d;
    logic [N-1:0] grant_idx_q, grant_idx_d;
    logic         valid_q,     valid_d;

    // Arbitration result for the current cycle
    logic [N-1:0] sel;
    logic         found;
    logic [N-1:0] cand;

    // Owner gives the bus back: explicit Done or its request went away.
    // Both at once are one release.
    logic         release_req;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q,     cnt_d;
    logic          timeout_q, timeout_d;
    logic          hold_expired;
`endif

    // Rotating priority search: first set request at Pointer, Pointer+1, ...
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        // Walk from the farthest offset down so the nearest match wins last.
        for (int i = M - 1; i >= 0; i--) begin
            cand = pointer_q + N'(i);
            if (bus.Req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign release_req = bus.Done | ~bus.Req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
    assign hold_expired = (cnt_q == CW'(TIMEOUT - 1));
`endif

    // Next-state and next-output computation for the IDLE/GRANT machine
    always_comb begin
        state_d     = state_q;
        pointer_d   = pointer_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        valid_d     = valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                // Done is meaningless without an owner and is ignored here.
                if (found) begin
                    state_d     = GRANT;
                    grant_idx_d = sel;
                    grant_d     = M'(1) << sel;
                    valid_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (release_req || hold_expired) begin
                    // A normal release wins over an expiry in the same cycle.
                    timeout_d = ~release_req;
`else
                if (release_req) begin
`endif
                    state_d     = IDLE;
                    grant_d     = '0;
                    grant_idx_d = '0;
                    valid_d     = 1'b0;
                    pointer_d   = grant_idx_q + N'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!Reset) begin
            state_q     <= IDLE;
            pointer_q   <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            valid_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pointer_q   <= pointer_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            valid_q     <= valid_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.Grant    = grant_q;
    assign bus.GrantIdx = grant_idx_q;
    assign bus.Valid    = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.Timeout  = timeout_q;
`else
    assign bus.Timeout  = 1'b0;
`endif

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter with N=2 (four requesters), TIMEOUT=16.
// Build with ARB_TIMEOUT_EN defined to exercise the forced-release path.
// Observed state is printed as {Grant, GrantIdx, Valid, Timeout}.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N = 2;
    localparam int M = 4;

    logic Clk;
    logic Reset;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    bus_arbiter_if #(.N(N)) bus ();

    bus_arbiter #(
        .N       (N),
        .M       (M),
        .TIMEOUT (16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle; outputs then reflect that edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {bus.Grant, bus.GrantIdx, bus.Valid, bus.Timeout};
    endfunction

    function automatic logic [7:0] exp_st(input logic [3:0] g, input logic [1:0] idx,
                                          input logic v, input logic t);
        return {g, idx, v, t};
    endfunction

    task automatic do_reset();
        Reset    = 1'b0;
        bus.Req  = '0;
        bus.Done = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    // Structural invariant: Grant is the decoded GrantIdx while Valid, else 0.
    always @(negedge Clk) begin
        if (mon_en) begin
            logic [3:0] want;
            want = bus.Valid ? (4'b0001 << bus.GrantIdx) : 4'b0000;
            n_checks++;
            if (bus.Grant !== want) begin
                n_fail++;
                $display("FAIL invariant_onehot: Grant=%b Valid=%b Idx=%0d want Grant=%b",
                         bus.Grant, bus.Valid, bus.GrantIdx, want);
            end
        end
    end

    task automatic test_reset();
        Reset    = 1'b0;
        bus.Req  = 4'b1111;
        bus.Done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
        mon_en = 1'b1;
        Reset  = 1'b1;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want %b", obs(), exp_st(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        bus.Req = 4'b0000;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        bus.Req = 4'b0100;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0100, 2'd2, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL single_grant: got %b want %b", obs(), exp_st(4'b0100, 2'd2, 1'b1, 1'b0));
        end
        // Done is not qualified by a request change; request stays up.
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL single_done_release: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
        // Pointer is now 3: with everyone requesting, 3 must win.
        bus.Req = 4'b1111;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b1000, 2'd3, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL single_pointer_advance: got %b want %b", obs(), exp_st(4'b1000, 2'd3, 1'b1, 1'b0));
        end
        bus.Req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (obs() !== exp_st(4'b0001 << seq[k], seq[k], 1'b1, 1'b0)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b want %b", k, obs(),
                         exp_st(4'b0001 << seq[k], seq[k], 1'b1, 1'b0));
            end
            bus.Done = 1'b1;
            tick();
            bus.Done = 1'b0;
            n_checks++;
            if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL rr_idle_gap_%0d: got %b want %b", k, obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
            end
        end
        bus.Req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap_no_preempt();
        do_reset();
        bus.Req = 4'b1000;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b1000, 2'd3, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL wrap_owner3: got %b want %b", obs(), exp_st(4'b1000, 2'd3, 1'b1, 1'b0));
        end
        // Requester 0 arrives; owner 3 must keep the bus.
        bus.Req = 4'b1001;
        tick();
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b1000, 2'd3, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL no_preempt: got %b want %b", obs(), exp_st(4'b1000, 2'd3, 1'b1, 1'b0));
        end
        bus.Req = 4'b0001;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL wrap_req_drop: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
        // Pointer wrapped to 0, so 0 beats the returning request 3.
        bus.Req = 4'b1001;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL wrap_next_is_0: got %b want %b", obs(), exp_st(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        bus.Req = 4'b0000;
        tick();
    endtask

    task automatic test_simultaneous_release();
        do_reset();
        bus.Req = 4'b0010;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0010, 2'd1, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL simul_owner1: got %b want %b", obs(), exp_st(4'b0010, 2'd1, 1'b1, 1'b0));
        end
        bus.Req  = 4'b0000;
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL simul_release: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
        // Single advance leaves Pointer at 2; a double advance would pick 3.
        bus.Req = 4'b1111;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0100, 2'd2, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL simul_single_advance: got %b want %b", obs(), exp_st(4'b0100, 2'd2, 1'b1, 1'b0));
        end
        bus.Req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        bus.Req = 4'b0001;
        tick();
        bad = 0;
`ifdef ARB_TIMEOUT_EN
        // Sixteen GRANT cycles, then a forced release with a Timeout pulse.
        for (int k = 1; k < 16; k++) begin
            tick();
            if (obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) bad++;
        end
        n_checks++;
        if (bad != 0 || obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_hold: %0d bad cycles, last got %b want %b", bad, obs(),
                     exp_st(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL timeout_force: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b1));
        end
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_pulse_end: got %b want %b", obs(), exp_st(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        // Normal release on the expiry cycle wins: no Timeout pulse.
        for (int k = 1; k < 16; k++) tick();
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_precedence: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
`else
        // No timeout hardware: the grant survives well past 100 cycles.
        for (int k = 0; k < 110; k++) begin
            tick();
            if (obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_timeout_hold: %0d bad cycles, last got %b want %b", bad, obs(),
                     exp_st(4'b0001, 2'd0, 1'b1, 1'b0));
        end
`endif
        bus.Req = 4'b0000;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_final_release: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_during_grant();
        bus.Req = 4'b0100;
        tick();
        Reset = 1'b0;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_in_grant: got %b want %b", obs(), exp_st(4'b0000, 2'd0, 1'b0, 1'b0));
        end
        // Pointer cleared to 0, so 0 wins over 2.
        Reset   = 1'b1;
        bus.Req = 4'b0101;
        tick();
        n_checks++;
        if (obs() !== exp_st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_clears_pointer: got %b want %b", obs(), exp_st(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        bus.Req = 4'b0000;
        tick();
    endtask

    initial begin
        Reset    = 1'b0;
        bus.Req  = '0;
        bus.Done = 1'b0;
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_wrap_no_preempt();
        test_simultaneous_release();
        test_timeout();
        test_reset_during_grant();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares the MERC-16 memory/peripheral bus among M requesters. It holds an N-bit grant index and drives a one-hot grant vector, which is the decoded form of that index. Grants are held until the owner releases the bus. It sits between the requesting units (fetch, load/store, DMA, debug) and the bus mux select.

Parameters:
N, 2, width of grant index
M, 2**N, number of requesters; always equal to 2**N
TIMEOUT, 16, maximum cycles a grant may be held; used only with ARB_TIMEOUT_EN

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
Req  input  M  request vector; bit i = requester i wants the bus
Done  input  1  current owner releases the bus this cycle
Grant  output  M  one-hot grant; all zeros when no owner
GrantIdx  output  N  index of current owner; 0 when no owner
Valid  output  1  high while a grant is held
Timeout  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset: sampled on a Clk edge while Reset=0. Clears Grant=0, GrantIdx=0, Valid=0, Timeout=0, Pointer=0, counter=0; state=IDLE. Reset during GRANT drops the grant at that edge.
- Internal Pointer (N bits): the first index to consider in the next arbitration.
- States: IDLE and GRANT. All outputs are registered.
- IDLE:
  - If Req != 0, select the first set bit scanning Pointer, Pointer+1, ... M-1, 0, ... (mod M).
  - Next edge: GrantIdx=sel, Grant=1<<sel, Valid=1, state=GRANT.
  - Latency from Req asserted to Grant: 1 cycle.
  - If Req == 0, stay in IDLE.
  - Done is ignored in IDLE.
- GRANT: a release occurs when Done=1, or when Req[GrantIdx]=0. Both together count as a single release. On release, at the next edge:
  - Grant=0, Valid=0, GrantIdx=0, state=IDLE.
  - Pointer = old GrantIdx+1 mod M (M-1 wraps to 0).
- Requests from non-owners never preempt the owner.
- One mandatory IDLE cycle between consecutive grants. Back-to-back grants are therefore spaced 2 cycles apart.
- Invariants:
  - Grant is always zero or one-hot.
  - Grant == (Valid ? 1<<GrantIdx : 0).
  - Valid == (state==GRANT).
- Fairness: under continuous requests from all M requesters, each is granted exactly once per M grants.

Optional Feature:
Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT)+1 clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT-1 with no release, the next edge force-releases exactly like a normal release (Pointer advances).
  - Timeout=1 for that one cycle, coincident with Grant going to 0. Timeout=0 otherwise.
  - A normal release in the same cycle takes precedence, and Timeout stays 0.
- Not defined: no counter exists, Timeout is tied to 0, and a grant is held indefinitely until released.

Test Plan:
- Reset=0 for 2 cycles with Req=4'b1111 -> Grant=0, GrantIdx=0, Valid=0; first cycle after Reset=1 -> Grant=4'b0001 one edge later.
- M=4, Pointer=0, Req=4'b0100 -> after 1 edge Grant=4'b0100, GrantIdx=2; pulse Done -> Grant=0 next edge, Pointer=3.
- Req held at 4'b1111, Done pulsed each grant -> grant sequence 0,1,2,3,0 with one Valid=0 cycle between each.
- Owner 3 granted, Req=4'b1001 -> drop Req[3] -> release; next grant is index 0 (wrap), not 3.
- Owner 1 granted, Req[1] and Done drop/assert in the same cycle -> single release, Pointer=2, no double advance.
- ARB_TIMEOUT_EN, TIMEOUT=16, owner holds with Done=0 -> Grant drops after 16 GRANT cycles with a one-cycle Timeout=1. Repeat without the macro -> grant held past 100 cycles, Timeout stays 0.
